disp_src_arbiter: RTL and testbench
===================================

// Module: disp_src_arbiter
// PURPOSE
//  Shares the 8-digit 7-seg display buffer between NREQ sources (key entry, calc result, error msg).
//  Selects one owner and drives its 32-bit nibble-packed word to the scan driver.
//  Ownership changes only on frame boundaries, so a scan frame never mixes two sources.
//  Sits between the source blocks and the digit scan/segment decode stage.
// PARAMETERS
//  NREQ         3   number of requesters; index 0 = highest priority
//  DISP_W       32  display word width (8 digits x 4 bits)
//  HOLD_FRAMES  4   minimum frames an owner keeps the display before preemption; 1..255
// PORTS
//  CLK         in   1            system clock, 24 MHz
//  nRST        in   1            asynchronous active-low reset
//  frame_tick  in   1            1-cycle pulse from scan driver at digit-select wrap (frame start)
//  req         in   NREQ         level request per source; held until the source is done
//  req_data    in   NREQ*DISP_W  source words; source i in [i*DISP_W +: DISP_W]
//  gnt         out  NREQ         one-hot owner; all-zero = no owner
//  disp_data   out  DISP_W       word to the scan driver
//  owner_chg   out  1            1-cycle pulse when gnt changes to a new non-zero value
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, disp_data=0, owner_chg=0, hold_cnt=0, winner=0.
//  Winner: lowest asserted req index in fixed-priority mode.
//  States:
//   IDLE:   gnt=0; disp_data holds its last value. Any req -> latch winner, go to SWITCH next cycle.
//           A frame_tick in the same cycle is not used; SWITCH waits for the next tick.
//   SWITCH: gnt=0. Wait for frame_tick.
//           If req[winner] deasserts first -> IDLE (re-arbitrate next cycle).
//           On frame_tick with req[winner]=1: gnt<=onehot(winner), disp_data<=word(winner),
//           hold_cnt<=0, owner_chg<=1, go to OWN. All take effect the cycle after the tick.
//   OWN:    On each frame_tick: disp_data<=word(owner); hold_cnt saturating +1 up to HOLD_FRAMES.
//           No mid-frame data updates.
//           req[owner] drops -> gnt<=0 next cycle, go to IDLE; disp_data keeps its last frame.
//           hold_cnt==HOLD_FRAMES and a higher-priority req is asserted -> gnt<=0,
//           winner<=that index, go to SWITCH.
//           An owner drop and a preempt in the same cycle: the drop wins -> IDLE.
//  Latency: worst case from req to gnt = 1 cycle + up to one frame + 1 cycle.
//  A source must not deassert req without first having seen gnt, except to abandon the request.
//  gnt is always one-hot or zero; it is never non-zero outside OWN.
//  Asserting nRST mid-operation returns to the reset values immediately (async).
// CONFIGURATION
//  DISP_ARB_RR_EN defined: round-robin winner, searching upward (with wrap) from last_owner+1.
//   In OWN, any other asserted req preempts after the hold expires, regardless of index.
//   last_owner resets to NREQ-1, so the first search starts at index 0.
//  Not defined: fixed priority as above; no last_owner register.
// STRUCTURE
//  Shared include disp_defs.vh: DISP_W, state encodings ST_IDLE/ST_SWITCH/ST_OWN (2-bit),
//   digit count.
//  One sub-module, arb_pick: combinational winner select (req, mask/start index -> index, valid).
//   It carries both the fixed-priority and the round-robin variant.
//  Top level holds the FSM, hold_cnt, the data mux and the output registers.
// TESTING
//  1. Reset, then req=3'b010 and tick every 16 cycles -> gnt=010 one cycle after the 1st tick;
//     disp_data=word1; owner_chg pulses once.
//  2. Owner 1 held; req[0] rises at frame 2 -> no preempt until hold_cnt=4;
//     gnt=001 one cycle after the tick that follows.
//  3. Owner 0 with req[2] asserted (fixed mode) -> gnt stays 001 indefinitely;
//     drop req[0] -> gnt=0 next cycle, then 100 after a tick.
//  4. In SWITCH, drop req[winner] before the tick -> IDLE, gnt never asserts, disp_data unchanged.
//  5. Change word0 mid-frame while owner is 0 -> disp_data changes only the cycle after frame_tick.
//  6. DISP_ARB_RR_EN, all req=111, HOLD_FRAMES=1 -> owners 0,1,2,0 on successive
//     hold expiries; pulse nRST low mid-OWN -> gnt=0, disp_data=0.

Source files
------------

// File: rtl/disp_src_arbiter_pkg.sv
// Shared definitions for the display source arbiter: word geometry,
// FSM state encoding, hold counter width and an index-width helper.
package disp_src_arbiter_pkg;

  localparam int DISP_DIGITS = 8;
  localparam int DIGIT_W     = 4;
  localparam int DISP_WORD_W = DISP_DIGITS * DIGIT_W;

  // Holds HOLD_FRAMES up to 255.
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_OWN    = 2'd2
  } arb_state_t;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_src_arbiter_arb_pick.sv
// Combinational winner select. RR=0: lowest set candidate index.
// RR=1: first set candidate found searching upward from 'start', wrapping.
// 'start' must be below NREQ.
module arb_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2,
  parameter bit RR   = 1'b0
) (
  input  logic [NREQ-1:0] cand,
  input  logic [IW-1:0]   start,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // Walk every candidate once in search order; the first hit wins.
  always_comb begin
    int pos;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = RR ? (int'(start) + k) : k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!valid && cand[pos]) begin
        idx   = IW'(pos);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_src_arbiter.sv
// Display source arbiter: picks one of NREQ sources to own the 8-digit
// display word and switches owners only on frame_tick, so a scan frame
// never mixes two sources.
// Build option: DISP_ARB_RR_EN selects round-robin arbitration (search from
// last_owner+1, any other requester preempts after the hold). Undefined:
// fixed priority, index 0 highest, only lower indices preempt.
//
// Handshake: req[i] is a level held by source i until it is done with the
// display; gnt[i] is the registered one-hot answer. A source that drops req
// before seeing gnt abandons its request; dropping req while granted
// releases the display on the next cycle.
module disp_src_arbiter
  import disp_src_arbiter_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int DISP_W      = DISP_WORD_W,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   frame_tick,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DISP_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [DISP_W-1:0]      disp_data,
  output logic                   owner_chg,
  output logic [1:0]             dbg_state
);

  localparam int              IW       = idx_w(NREQ);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);

`ifdef DISP_ARB_RR_EN
  localparam bit RR = 1'b1;
  logic [IW-1:0] last_owner, last_n;
`else
  localparam bit RR = 1'b0;
`endif

  arb_state_t          state, state_n;
  logic [IW-1:0]       winner, winner_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [NREQ-1:0]     gnt_n;
  logic [DISP_W-1:0]   disp_n;
  logic                chg_n;

  logic [NREQ-1:0]     owner_oh, pre_mask;
  logic [IW-1:0]       new_start, pre_start, new_idx, pre_idx;
  logic                new_vld, pre_vld;
  logic [DISP_W-1:0]   win_word;

  // Index increment with wrap at NREQ-1.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  assign dbg_state = state;
  assign win_word  = req_data[int'(winner) * DISP_W +: DISP_W];

  // Owner one-hot plus search start points and the preemption candidate mask.
  always_comb begin
    owner_oh         = '0;
    owner_oh[winner] = 1'b1;
    pre_mask         = '0;
    new_start        = '0;
    pre_start        = '0;
`ifdef DISP_ARB_RR_EN
    pre_mask  = ~owner_oh;
    new_start = next_idx(last_owner);
    pre_start = next_idx(winner);
`else
    for (int k = 0; k < NREQ; k++) pre_mask[k] = (k < int'(winner));
`endif
  end

  // Picker for a fresh arbitration out of IDLE.
  arb_pick #(.NREQ(NREQ), .IW(IW), .RR(RR)) u_pick_new (
    .cand  (req),
    .start (new_start),
    .idx   (new_idx),
    .valid (new_vld)
  );

  // Picker for a requester allowed to preempt the current owner.
  arb_pick #(.NREQ(NREQ), .IW(IW), .RR(RR)) u_pick_pre (
    .cand  (req & pre_mask),
    .start (pre_start),
    .idx   (pre_idx),
    .valid (pre_vld)
  );

  // Next-state and next-output logic; owner changes land only after a frame_tick.
  always_comb begin
    state_n  = state;
    winner_n = winner;
    hold_n   = hold_cnt;
    gnt_n    = gnt;
    disp_n   = disp_data;
    chg_n    = 1'b0;
`ifdef DISP_ARB_RR_EN
    last_n   = last_owner;
`endif
    unique case (state)
      ST_IDLE: begin
        gnt_n = '0;
        if (new_vld) begin
          winner_n = new_idx;
          state_n  = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        gnt_n = '0;
        if (!req[winner]) begin
          state_n = ST_IDLE;
        end else if (frame_tick) begin
          gnt_n   = owner_oh;
          disp_n  = win_word;
          hold_n  = '0;
          chg_n   = 1'b1;
          state_n = ST_OWN;
`ifdef DISP_ARB_RR_EN
          last_n  = winner;
`endif
        end
      end
      ST_OWN: begin
        if (!req[winner]) begin
          // Release wins over any preemption; the last frame stays on display.
          gnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          if (frame_tick) begin
            disp_n = win_word;
            if (hold_cnt < HOLD_MAX) hold_n = hold_cnt + 1'b1;
          end
          if ((hold_cnt == HOLD_MAX) && pre_vld) begin
            gnt_n    = '0;
            winner_n = pre_idx;
            state_n  = ST_SWITCH;
          end
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= ST_IDLE;
      winner     <= '0;
      hold_cnt   <= '0;
      gnt        <= '0;
      disp_data  <= '0;
      owner_chg  <= 1'b0;
`ifdef DISP_ARB_RR_EN
      last_owner <= LAST_IDX;
`endif
    end else begin
      state      <= state_n;
      winner     <= winner_n;
      hold_cnt   <= hold_n;
      gnt        <= gnt_n;
      disp_data  <= disp_n;
      owner_chg  <= chg_n;
`ifdef DISP_ARB_RR_EN
      last_owner <= last_n;
`endif
    end
  end

endmodule

// File: tb/tb_disp_src_arbiter.sv
// Bench for disp_src_arbiter: directed scenarios with literal expectations,
// then randomized requesters checked every cycle against an ownership model.
`timescale 1ns/1ps
module tb_disp_src_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int EW   = NREQ + DW + 1;
`ifdef DISP_ARB_RR_EN
  localparam int HOLD = 1;
`else
  localparam int HOLD = 4;
`endif

  logic                 CLK;
  logic                 nRST;
  logic                 frame_tick;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      gnt;
  logic [DW-1:0]        disp_data;
  logic                 owner_chg;
  logic [1:0]           dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;

  disp_src_arbiter #(.NREQ(NREQ), .DISP_W(DW), .HOLD_FRAMES(HOLD)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .frame_tick (frame_tick),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .disp_data  (disp_data),
    .owner_chg  (owner_chg),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got still running, want finished");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return req_data[i*DW +: DW];
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Next owner out of an idle display.
  function automatic int pick_new(input int last);
    int r;
    r = -1;
`ifdef DISP_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++) if (r < 0 && req[(last + k) % NREQ]) r = (last + k) % NREQ;
`else
    for (int i = 0; i < NREQ; i++) if (r < 0 && req[i]) r = i;
`endif
    return r;
  endfunction

  // Requester entitled to take over from 'own' once the hold has expired.
  function automatic int pick_preempt(input int own);
    int r;
    r = -1;
`ifdef DISP_ARB_RR_EN
    for (int k = 1; k < NREQ; k++) if (r < 0 && req[(own + k) % NREQ]) r = (own + k) % NREQ;
`else
    for (int i = 0; i < own; i++) if (r < 0 && req[i]) r = i;
`endif
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Tracks who owns the display, who is waiting for the next frame, how many
  // frames the owner has held it, and what is on the display.
  int            m_owner  = -1;
  int            m_wait   = -1;
  int            m_frames = 0;
  int            m_last   = NREQ - 1;
  logic [DW-1:0] m_data   = '0;

  // Advance the model one clock and queue the outputs it predicts.
  always @(posedge CLK or negedge nRST) begin
    int o, w, f, l, p;
    logic [DW-1:0]   d;
    logic            c;
    logic [NREQ-1:0] g;
    if (!nRST) begin
      m_owner  <= -1;
      m_wait   <= -1;
      m_frames <= 0;
      m_last   <= NREQ - 1;
      m_data   <= '0;
      exp_q.delete();
    end else begin
      o = m_owner; w = m_wait; f = m_frames; l = m_last; d = m_data; c = 1'b0; p = -1;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          o = -1;
        end else begin
          if (frame_tick) begin
            d = word_of(m_owner);
            f = (m_frames + 1 > HOLD) ? HOLD : m_frames + 1;
          end
          if (m_frames == HOLD) p = pick_preempt(m_owner);
          if (p >= 0) begin
            w = p;
            o = -1;
          end
        end
      end else if (m_wait >= 0) begin
        if (!req[m_wait]) begin
          w = -1;
        end else if (frame_tick) begin
          o = m_wait; w = -1; d = word_of(m_wait); f = 0; c = 1'b1; l = m_wait;
        end
      end else if (req != '0) begin
        w = pick_new(m_last);
      end
      m_owner  <= o;
      m_wait   <= w;
      m_frames <= f;
      m_last   <= l;
      m_data   <= d;
      g = '0;
      if (o >= 0) g[o] = 1'b1;
      exp_q.push_back({g, d, c});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model_gnt",       32'(gnt),       32'(e[EW-1 -: NREQ]));
      check("model_disp_data", disp_data,      e[DW:1]);
      check("model_owner_chg", 32'(owner_chg), 32'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit tk);
    frame_tick = tk;
    @(negedge CLK);
    frame_tick = 1'b0;
  endtask

  task automatic frame();
    repeat (15) step(1'b0);
    step(1'b1);
  endtask

  task automatic reset_pulse_check();
    #2 nRST = 1'b0;
    #1;
    check("async_rst_gnt",  32'(gnt),       32'd0);
    check("async_rst_data", disp_data,      32'd0);
    check("async_rst_chg",  32'(owner_chg), 32'd0);
    @(negedge CLK);
    #2 nRST = 1'b1;
    @(negedge CLK);
  endtask

  localparam logic [DW-1:0] W0  = 32'h1111_2222;
  localparam logic [DW-1:0] W1  = 32'h3333_4444;
  localparam logic [DW-1:0] W2  = 32'h5555_6666;
  localparam logic [DW-1:0] W0B = 32'h7777_8888;

  int  life[NREQ];
  int  seen[4];
  int  nseen;
  int  tick_gap;
  int  sel;
  bit  tk;

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0;
    frame_tick = 1'b0;
    req = '0;
    req_data = {W2, W1, W0};
    repeat (3) @(negedge CLK);
    check("reset_gnt",   32'(gnt),       32'd0);
    check("reset_data",  disp_data,      32'd0);
    check("reset_chg",   32'(owner_chg), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

`ifdef DISP_ARB_RR_EN
    // All sources request with a one-frame hold: ownership rotates 0,1,2,0.
    req = '1;
    nseen = 0;
    for (int i = 0; i < 4; i++) seen[i] = 99;
    for (int c = 0; c < 400 && nseen < 4; c++) begin
      step((c % 16) == 15);
      if (owner_chg) begin
        seen[nseen] = oh_idx(gnt);
        nseen++;
      end
    end
    check("rr_owner_count", nseen,   4);
    check("rr_owner_1st",   seen[0], 0);
    check("rr_owner_2nd",   seen[1], 1);
    check("rr_owner_3rd",   seen[2], 2);
    check("rr_owner_4th",   seen[3], 0);
    check("rr_gnt_before_rst", 32'(gnt), 32'b001);
    reset_pulse_check();
`else
    // Single requester: granted the cycle after the first tick it waits for.
    req = 3'b010;
    step(1'b0); step(1'b0);
    step(1'b1);
    check("t1_gnt",  32'(gnt),       32'b010);
    check("t1_data", disp_data,      W1);
    check("t1_chg",  32'(owner_chg), 32'd1);
    step(1'b0);
    check("t1_chg_pulse", 32'(owner_chg), 32'd0);

    // Higher priority arrives at frame 2; waits until the hold has expired.
    frame();
    req = 3'b011;
    frame();
    check("t2_hold2_gnt", 32'(gnt), 32'b010);
    frame();
    check("t2_hold3_gnt", 32'(gnt), 32'b010);
    frame();
    check("t2_hold4_gnt", 32'(gnt), 32'b010);
    step(1'b0);
    check("t2_preempt_gnt", 32'(gnt), 32'b000);
    frame();
    check("t2_new_gnt",  32'(gnt), 32'b001);
    check("t2_new_data", disp_data, W0);

    // Owner 0 is never preempted by a lower priority; its word updates only on ticks.
    req = 3'b101;
    repeat (3) begin
      frame();
      check("t3_keep_gnt", 32'(gnt), 32'b001);
    end
    repeat (5) step(1'b0);
    req_data[0 +: DW] = W0B;
    repeat (10) step(1'b0);
    check("t5_mid_frame_data", disp_data, W0);
    step(1'b1);
    check("t5_after_tick_data", disp_data, W0B);
    req = 3'b100;
    step(1'b0);
    check("t3_drop_gnt", 32'(gnt), 32'b000);
    step(1'b0);
    frame();
    check("t3_next_gnt",  32'(gnt), 32'b100);
    check("t3_next_data", disp_data, W2);

    // Abandoned request in SWITCH: display untouched, never granted.
    req = 3'b000;
    step(1'b0);
    req = 3'b010;
    step(1'b0);
    req = 3'b000;
    step(1'b0);
    repeat (2) begin
      frame();
      check("t4_gnt",  32'(gnt), 32'b000);
      check("t4_data", disp_data, W2);
    end

    // Async reset while an owner holds the display.
    req = 3'b001;
    step(1'b0);
    frame();
    step(1'b0);
    check("rst_pre_gnt", 32'(gnt), 32'b001);
    reset_pulse_check();
`endif

    // Random requesters, word updates, irregular frames and one mid-run reset.
    req = '0;
    for (int i = 0; i < NREQ; i++) life[i] = 0;
    tick_gap = 5;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (life[i] == 0) req[i] = 1'b0;
          else life[i]--;
        end else if ($urandom_range(0, 7) == 0) begin
          req[i]  = 1'b1;
          life[i] = $urandom_range(2, 150);
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        sel = $urandom_range(0, NREQ - 1);
        req_data[sel*DW +: DW] = $urandom();
      end
      tk = (tick_gap == 0);
      if (tk) tick_gap = $urandom_range(3, 20);
      else tick_gap--;
      if (cyc == 1500) reset_pulse_check();
      step(tk);
    end
    repeat (2) step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
